// File: rtl/cmd_assembler.sv
// Collects the serial field stream (action, formula, mode, date, data_no, indices) into one
// packed command and hands it to the core over a valid/ready handshake.
//
// state  | meaning
// S_IDLE | waiting for an action field
// S_FORM | Index_Check: waiting for formula
// S_MODE | Index_Check: waiting for mode
// S_DATE | waiting for month/day
// S_NO   | waiting for data_no
// S_IDX  | collecting NUM_IDX indices
// S_OUT  | command held valid until the consumer takes it
module cmd_assembler #(
    parameter int NUM_IDX = 4,
    parameter int IDX_W   = 12,
    parameter int ADDR_W  = 8,
    parameter int D_W     = 12
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     in_valid_act,
    input  logic                     in_valid_formula,
    input  logic                     in_valid_mode,
    input  logic                     in_valid_date,
    input  logic                     in_valid_no,
    input  logic                     in_valid_idx,
    input  logic [D_W-1:0]           in_data,
    input  logic                     cmd_ready,
    output logic                     cmd_valid,
    output logic [1:0]               cmd_act,
    output logic [2:0]               cmd_formula,
    output logic [1:0]               cmd_mode,
    output logic [3:0]               cmd_month,
    output logic [4:0]               cmd_day,
    output logic [ADDR_W-1:0]        cmd_no,
    output logic [NUM_IDX*IDX_W-1:0] cmd_idx,
    output logic                     date_ok,
    output logic                     busy,
    output logic                     proto_err
);

    localparam int CNT_W = (NUM_IDX > 1) ? $clog2(NUM_IDX) : 1;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_IDX - 1);

    typedef enum logic [2:0] {S_IDLE, S_FORM, S_MODE, S_DATE, S_NO, S_IDX, S_OUT} state_t;

    state_t                   state_q;
    logic [CNT_W-1:0]         cnt_q;
    logic                     cmd_valid_q;
    logic [1:0]               act_q;
    logic [2:0]               formula_q;
    logic [1:0]               mode_q;
    logic [3:0]               month_q;
    logic [4:0]               day_q;
    logic [ADDR_W-1:0]        no_q;
    logic [NUM_IDX*IDX_W-1:0] idx_q;
    logic                     date_ok_q;
    logic                     proto_err_q;

    logic [5:0] vld, exp_v;
    logic       multi, stray, bad_val, accept, go_idle;

    function automatic logic date_legal(input logic [3:0] m, input logic [4:0] d);
        logic [4:0] dim;
        case (m)
            4'd2:                      dim = 5'd28;
            4'd4, 4'd6, 4'd9, 4'd11:   dim = 5'd30;
            default:                   dim = 5'd31;
        endcase
        return (m >= 4'd1) && (m <= 4'd12) && (d >= 5'd1) && (d <= dim);
    endfunction

    // One-hot field valids; bit order matches the order fields arrive in a full command.
    always_comb begin
        vld = {in_valid_idx, in_valid_no, in_valid_date, in_valid_mode, in_valid_formula, in_valid_act};
        case (state_q)
            S_IDLE:  exp_v = 6'b000001;
            S_FORM:  exp_v = 6'b000010;
            S_MODE:  exp_v = 6'b000100;
            S_DATE:  exp_v = 6'b001000;
            S_NO:    exp_v = 6'b010000;
            S_IDX:   exp_v = 6'b100000;
            default: exp_v = 6'b000000;
        endcase
        multi   = (vld & (vld - 6'd1)) != 6'd0;
        stray   = (vld != 6'd0) && (multi || ((vld & ~exp_v) != 6'd0));
        bad_val = (in_valid_act && in_data[1:0] == 2'b11) || (in_valid_mode && in_data[1:0] == 2'b10);
        accept  = (vld != 6'd0) && !stray && !bad_val;
        // In OUT a protocol error only pulses; the held command survives until handshake.
        go_idle = (state_q == S_OUT) ? cmd_ready : (stray || bad_val);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            cmd_valid_q <= 1'b0;
            act_q       <= '0;
            formula_q   <= '0;
            mode_q      <= '0;
            month_q     <= '0;
            day_q       <= '0;
            no_q        <= '0;
            idx_q       <= '0;
            date_ok_q   <= 1'b0;
            proto_err_q <= 1'b0;
        end else begin
            proto_err_q <= stray || bad_val;
            if (accept) begin
                case (state_q)
                    S_IDLE: begin
                        act_q   <= in_data[1:0];
                        state_q <= (in_data[1:0] == 2'b00) ? S_FORM : S_DATE;
                    end
                    S_FORM: begin
                        formula_q <= in_data[2:0];
                        state_q   <= S_MODE;
                    end
                    S_MODE: begin
                        mode_q  <= in_data[1:0];
                        state_q <= S_DATE;
                    end
                    S_DATE: begin
                        month_q <= in_data[8:5];
                        day_q   <= in_data[4:0];
                        state_q <= S_NO;
                    end
                    S_NO: begin
                        no_q <= in_data[ADDR_W-1:0];
                        if (act_q == 2'b10) begin
                            state_q     <= S_OUT;
                            cmd_valid_q <= 1'b1;
                            date_ok_q   <= date_legal(month_q, day_q);
                        end else begin
                            state_q <= S_IDX;
                        end
                    end
                    S_IDX: begin
                        idx_q[cnt_q*IDX_W +: IDX_W] <= in_data[IDX_W-1:0];
                        if (cnt_q == LAST_IDX) begin
                            state_q     <= S_OUT;
                            cmd_valid_q <= 1'b1;
                            date_ok_q   <= date_legal(month_q, day_q);
                        end else begin
                            cnt_q <= cnt_q + 1'b1;
                        end
                    end
                    default: ;
                endcase
            end
            // Entering IDLE wipes every captured field so unused fields of the next command read 0.
            if (go_idle) begin
                state_q     <= S_IDLE;
                cnt_q       <= '0;
                cmd_valid_q <= 1'b0;
                act_q       <= '0;
                formula_q   <= '0;
                mode_q      <= '0;
                month_q     <= '0;
                day_q       <= '0;
                no_q        <= '0;
                idx_q       <= '0;
                date_ok_q   <= 1'b0;
            end
        end
    end

    assign cmd_valid   = cmd_valid_q;
    assign cmd_act     = act_q;
    assign cmd_formula = formula_q;
    assign cmd_mode    = mode_q;
    assign cmd_month   = month_q;
    assign cmd_day     = day_q;
    assign cmd_no      = no_q;
    assign cmd_idx     = idx_q;
    assign date_ok     = date_ok_q;
    assign busy        = (state_q != S_IDLE);
    assign proto_err   = proto_err_q;

endmodule

// File: tb/tb_cmd_assembler.sv
// Randomised scoreboard bench for cmd_assembler plus directed protocol, reset and wide-index cases.
module tb_cmd_assembler;

    localparam int NI = 4, IW = 12, AW = 8, DW = 12;
    localparam int NI2 = 6, IW2 = 16, DW2 = 16;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst_n;
    logic v_act, v_form, v_mode, v_date, v_no, v_idx, cmd_ready;
    logic [DW-1:0] in_data;
    logic cmd_valid, date_ok, busy, proto_err;
    logic [1:0] cmd_act, cmd_mode;
    logic [2:0] cmd_formula;
    logic [3:0] cmd_month;
    logic [4:0] cmd_day;
    logic [AW-1:0] cmd_no;
    logic [NI*IW-1:0] cmd_idx;

    cmd_assembler #(.NUM_IDX(NI), .IDX_W(IW), .ADDR_W(AW), .D_W(DW)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid_act(v_act), .in_valid_formula(v_form), .in_valid_mode(v_mode),
        .in_valid_date(v_date), .in_valid_no(v_no), .in_valid_idx(v_idx),
        .in_data(in_data), .cmd_ready(cmd_ready), .cmd_valid(cmd_valid),
        .cmd_act(cmd_act), .cmd_formula(cmd_formula), .cmd_mode(cmd_mode),
        .cmd_month(cmd_month), .cmd_day(cmd_day), .cmd_no(cmd_no), .cmd_idx(cmd_idx),
        .date_ok(date_ok), .busy(busy), .proto_err(proto_err));

    logic w_act, w_form, w_mode, w_date, w_no, w_idx, w_ready;
    logic [DW2-1:0] w_data;
    logic w_valid, w_ok, w_busy, w_err;
    logic [1:0] w_cact, w_cmode;
    logic [2:0] w_cform;
    logic [3:0] w_mon;
    logic [4:0] w_day;
    logic [AW-1:0] w_no_o;
    logic [NI2*IW2-1:0] w_idx_o;

    cmd_assembler #(.NUM_IDX(NI2), .IDX_W(IW2), .ADDR_W(AW), .D_W(DW2)) dut_wide (
        .clk(clk), .rst_n(rst_n),
        .in_valid_act(w_act), .in_valid_formula(w_form), .in_valid_mode(w_mode),
        .in_valid_date(w_date), .in_valid_no(w_no), .in_valid_idx(w_idx),
        .in_data(w_data), .cmd_ready(w_ready), .cmd_valid(w_valid),
        .cmd_act(w_cact), .cmd_formula(w_cform), .cmd_mode(w_cmode),
        .cmd_month(w_mon), .cmd_day(w_day), .cmd_no(w_no_o), .cmd_idx(w_idx_o),
        .date_ok(w_ok), .busy(w_busy), .proto_err(w_err));

    typedef struct packed {
        logic [1:0]       act;
        logic [2:0]       f;
        logic [1:0]       m;
        logic [3:0]       mon;
        logic [4:0]       day;
        logic [AW-1:0]    no;
        logic [NI*IW-1:0] idx;
        logic             ok;
    } rec_t;

    rec_t exp_q[$];
    int   checks = 0, errors = 0;
    int   exp_err = 0, seen_err = 0;
    int   dim_tab [0:12] = '{0, 31, 28, 31, 30, 31, 30, 31, 31, 30, 31, 30, 31};
    logic rdy_force = 1'b1, rdy_val = 1'b0;

    task automatic chk(input string nm, input logic [127:0] a, input logic [127:0] e);
        checks++;
        if (a !== e) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, a, e);
        end
    endtask

    function automatic logic legal(input int mon, input int day);
        if (mon < 1 || mon > 12) return 1'b0;
        return (day >= 1) && (day <= dim_tab[mon]);
    endfunction

    function automatic rec_t dut_rec();
        rec_t r;
        r = '{cmd_act, cmd_formula, cmd_mode, cmd_month, cmd_day, cmd_no, cmd_idx, date_ok};
        return r;
    endfunction

    // Consumer: random back-pressure unless a test pins cmd_ready.
    always @(posedge clk) begin
        #2;
        cmd_ready = rdy_force ? rdy_val : 1'($urandom_range(0, 1));
    end

    // Monitor / scoreboard.
    rec_t prev;
    logic hold_prev = 1'b0;
    always @(negedge clk) begin
        if (!rst_n) begin
            hold_prev = 1'b0;
        end else begin
            if (proto_err) seen_err++;
            if (cmd_valid) begin
                if (hold_prev) chk("stable_while_valid", 128'(dut_rec()), 128'(prev));
                if (cmd_ready) begin
                    if (exp_q.size() == 0) begin
                        chk("unexpected_cmd", 128'(dut_rec()), 128'(0));
                    end else begin
                        rec_t e;
                        e = exp_q.pop_front();
                        chk("cmd_act", 128'(cmd_act), 128'(e.act));
                        chk("cmd_formula", 128'(cmd_formula), 128'(e.f));
                        chk("cmd_mode", 128'(cmd_mode), 128'(e.m));
                        chk("cmd_date", 128'({cmd_month, cmd_day}), 128'({e.mon, e.day}));
                        chk("cmd_no", 128'(cmd_no), 128'(e.no));
                        chk("cmd_idx", 128'(cmd_idx), 128'(e.idx));
                        chk("date_ok", 128'(date_ok), 128'(e.ok));
                    end
                    hold_prev = 1'b0;
                end else begin
                    hold_prev = 1'b1;
                    prev = dut_rec();
                end
            end else begin
                hold_prev = 1'b0;
            end
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input int fld, input logic [DW-1:0] val);
        in_data = val;
        case (fld)
            0: v_act  = 1'b1;
            1: v_form = 1'b1;
            2: v_mode = 1'b1;
            3: v_date = 1'b1;
            4: v_no   = 1'b1;
            default: v_idx = 1'b1;
        endcase
        cyc();
        {v_act, v_form, v_mode, v_date, v_no, v_idx} = '0;
        in_data = '0;
    endtask

    task automatic gap();
        repeat ($urandom_range(0, 2)) cyc();
    endtask

    task automatic wait_idle();
        int n = 0;
        while ((busy || cmd_valid) && n < 200) begin
            cyc();
            n++;
        end
        if (n >= 200) chk("idle_timeout", 128'(busy), 128'(0));
    endtask

    function automatic logic [DW-1:0] date_word(input int mon, input int day);
        logic [8:0] w;
        w = {4'(mon), 5'(day)};
        return DW'(w);
    endfunction

    task automatic send_cmd(input int act, input int f, input int m, input int mon, input int day,
                            input int no, input logic [NI*IW-1:0] idx, input bit wait_done);
        rec_t e;
        e.act = 2'(act);
        e.f   = (act == 0) ? 3'(f) : 3'd0;
        e.m   = (act == 0) ? 2'(m) : 2'd0;
        e.mon = 4'(mon);
        e.day = 5'(day);
        e.no  = AW'(no);
        e.idx = (act == 2) ? '0 : idx;
        e.ok  = legal(mon, day);
        drive(0, DW'(act)); gap();
        if (act == 0) begin
            drive(1, DW'(f)); gap();
            drive(2, DW'(m)); gap();
        end
        drive(3, date_word(mon, day)); gap();
        if (act == 2) begin
            exp_q.push_back(e);
            drive(4, DW'(no));
        end else begin
            drive(4, DW'(no)); gap();
            for (int k = 0; k < NI; k++) begin
                if (k == NI - 1) exp_q.push_back(e);
                drive(5, DW'(idx[k*IW +: IW]));
                if (k < NI - 1) gap();
            end
        end
        chk("valid_latency", 128'(cmd_valid), 128'(1));
        if (wait_done) wait_idle();
    endtask

    // Expected protocol error raised by the last driven cycle.
    task automatic expect_err(input string nm);
        exp_err++;
        chk(nm, 128'({proto_err, busy}), 128'(2'b10));
    endtask

    initial begin
        logic [NI*IW-1:0]   ridx;
        logic [NI2*IW2-1:0] widx;
        {v_act, v_form, v_mode, v_date, v_no, v_idx} = '0;
        {w_act, w_form, w_mode, w_date, w_no, w_idx} = '0;
        in_data = '0; w_data = '0; w_ready = 1'b0; cmd_ready = 1'b0;
        rst_n = 1'b0;
        repeat (3) cyc();
        chk("reset_outputs", 128'({cmd_valid, busy, proto_err, date_ok, cmd_idx, cmd_no}), 128'(0));
        rst_n = 1'b1;
        cyc();

        // T1: Index_Check, 30 April legal.
        rdy_force = 1'b0;
        send_cmd(0, 2, 1, 4, 30, 8'h15, {12'h004, 12'h003, 12'h002, 12'h001}, 1'b1);

        // T2: Check_Valid_Date on 29 Feb, back-pressured for five valid cycles.
        rdy_force = 1'b1; rdy_val = 1'b0;
        send_cmd(2, 0, 0, 2, 29, 8'hFF, '0, 1'b0);
        repeat (4) begin
            cyc();
            chk("t2_valid_held", 128'(cmd_valid), 128'(1));
        end
        rdy_val = 1'b1;
        cyc();
        chk("t2_valid_dropped", 128'(cmd_valid), 128'(0));
        wait_idle();

        // T3: Update followed by a formula field.
        drive(0, 12'd1); drive(1, 12'd3);
        expect_err("t3_wrong_field");
        cyc();
        chk("t3_err_pulse_one_cycle", 128'(proto_err), 128'(0));

        // T4: date and data_no together.
        drive(0, 12'd1);
        in_data = date_word(5, 5); v_date = 1'b1; v_no = 1'b1;
        cyc();
        v_date = 1'b0; v_no = 1'b0;
        expect_err("t4_two_valids");

        drive(0, 12'd3);
        expect_err("illegal_action");
        drive(0, 12'd0); drive(1, 12'd5); drive(2, 12'd2);
        expect_err("illegal_mode");

        // Stray field while a command is held: command must survive.
        rdy_val = 1'b0;
        send_cmd(1, 0, 0, 12, 31, 8'h3C, {12'hABC, 12'h123, 12'hFFF, 12'h000}, 1'b0);
        drive(3, date_word(1, 1));
        exp_err++;
        chk("stray_in_out", 128'({proto_err, cmd_valid, busy}), 128'(3'b111));
        rdy_val = 1'b1;
        wait_idle();

        // Randomised mix of good commands and protocol violations.
        rdy_force = 1'b0;
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 4) == 0) begin
                case ($urandom_range(0, 2))
                    0: begin drive(0, 12'd3); expect_err("rand_bad_act"); end
                    1: begin drive(0, 12'd0); drive(1, 12'd1); drive(2, 12'd2); expect_err("rand_bad_mode"); end
                    default: begin drive(0, 12'd1); drive(5, 12'h777); expect_err("rand_wrong_field"); end
                endcase
            end else begin
                int act, m;
                act = $urandom_range(0, 2);
                m = $urandom_range(0, 2);
                if (m == 2) m = 3;
                for (int k = 0; k < NI; k++) ridx[k*IW +: IW] = IW'($urandom);
                send_cmd(act, $urandom_range(0, 7), m, $urandom_range(0, 15), $urandom_range(0, 31),
                         $urandom_range(0, 255), ridx, 1'b1);
            end
        end

        // T6: reset mid-command, then a clean Update.
        drive(0, 12'd1); drive(3, date_word(3, 3)); drive(4, 12'h10);
        drive(5, 12'h111); drive(5, 12'h222);
        rst_n = 1'b0;
        #1;
        chk("t6_reset_clears", 128'({busy, cmd_valid, cmd_idx, cmd_act}), 128'(0));
        cyc();
        rst_n = 1'b1;
        cyc();
        send_cmd(1, 0, 0, 7, 4, 8'h42, {12'hD00, 12'hC00, 12'hB00, 12'hA00}, 1'b1);

        // T5: wide instance, six 16-bit indices.
        w_data = 16'd1; w_act = 1'b1; cyc(); w_act = 1'b0;
        w_data = 16'h0021; w_date = 1'b1; cyc(); w_date = 1'b0;
        w_data = 16'h0009; w_no = 1'b1; cyc(); w_no = 1'b0;
        for (int k = 0; k < NI2; k++) begin
            w_data = 16'hA000 + 16'(k);
            widx[k*IW2 +: IW2] = 16'hA000 + 16'(k);
            w_idx = 1'b1;
            cyc();
        end
        w_idx = 1'b0;
        chk("t5_valid", 128'({w_valid, w_ok, w_err}), 128'(3'b110));
        chk("t5_idx_packed", 128'(w_idx_o), 128'(widx));
        chk("t5_lsb_slot", 128'(w_idx_o[15:0]), 128'(16'hA000));
        w_ready = 1'b1;
        cyc();
        chk("t5_handshake", 128'({w_valid, w_busy}), 128'(0));

        repeat (3) cyc();
        chk("proto_err_count", 128'(seen_err), 128'(exp_err));
        chk("scoreboard_drained", 128'(exp_q.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
